demux_1_to_2_reg: RTL and testbench

Registered 1-to-2 stream demultiplexer: the routing counterpart of the 2-to-1 data selector. A single valid/ready input stream is steered, beat by beat, to one of two output streams by a per-beat select bit. Each output has a one-entry holding register, so a stalled output never blocks beats bound for the other output once they are in its register. It sits between a single producer (e.g. a writeback or result bus) and two independent consumers. Per-output transfer counters are provided for debug and verification.

---
 rtl/demux_1_to_2_reg_pkg.sv | 8 +
 rtl/demux_1_to_2_reg_if.sv | 28 ++
 rtl/demux_1_to_2_reg_slot.sv | 43 ++++
 rtl/demux_1_to_2_reg.sv | 47 ++++
 tb/tb_demux_1_to_2_reg.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/demux_1_to_2_reg_pkg.sv
// Shared constants for the registered 1-to-2 stream demultiplexer.
package demux_pkg;
  localparam logic SEL_OUT0    = 1'b0;
  localparam logic SEL_OUT1    = 1'b1;
  localparam int   DEMUX_SIZE  = 32;
  localparam int   DEMUX_CNT_W = 8;
  localparam int   NUM_OUT     = 2;
endpackage

// File: rtl/demux_1_to_2_reg_if.sv
// Stream bundle: one valid/ready input, two valid/ready outputs, debug counters.
interface demux_1_to_2_reg_if #(
  parameter int size  = 32,
  parameter int CNT_W = 8
);
  logic [size-1:0]  data_i;
  logic             select_i;
  logic             valid_i;
  logic             ready_o;
  logic [size-1:0]  data0_o;
  logic             valid0_o;
  logic             ready0_i;
  logic [size-1:0]  data1_o;
  logic             valid1_o;
  logic             ready1_i;
  logic [CNT_W-1:0] count0_o;
  logic [CNT_W-1:0] count1_o;

  modport master (
    output data_i, select_i, valid_i, ready0_i, ready1_i,
    input  ready_o, data0_o, valid0_o, data1_o, valid1_o, count0_o, count1_o
  );

  modport slave (
    input  data_i, select_i, valid_i, ready0_i, ready1_i,
    output ready_o, data0_o, valid0_o, data1_o, valid1_o, count0_o, count1_o
  );
endinterface

// File: rtl/demux_1_to_2_reg_slot.sv
// Single-entry output register with fill/drain priority and a wrapping handshake counter.
module demux_out_slot #(
  parameter int size  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_fill,
  input  logic [size-1:0]  i_data,
  input  logic             i_ready,
  output logic             o_open,
  output logic             o_valid,
  output logic [size-1:0]  o_data,
  output logic [CNT_W-1:0] o_count
);
  logic [size-1:0]  r_data;
  logic             r_full;
  logic [CNT_W-1:0] r_count;
  logic             w_drain;

  assign w_drain = r_full && i_ready;
  // Open when empty or draining this cycle, so a full slot can stream 1 beat/cycle.
  assign o_open  = !r_full || i_ready;
  assign o_valid = r_full;
  assign o_data  = r_data;
  assign o_count = r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_full  <= 1'b0;
      r_count <= '0;
    end else begin
      if (i_fill) begin
        r_data <= i_data;
        r_full <= 1'b1;
      end else if (w_drain) begin
        r_full <= 1'b0;
      end
      if (w_drain) r_count <= r_count + 1'b1;
    end
  end
endmodule

// File: rtl/demux_1_to_2_reg.sv
// Registered 1-to-2 demux: select decode and ready mux around two output slots.
module demux_1_to_2_reg
  import demux_pkg::*;
#(
  parameter int size  = DEMUX_SIZE,
  parameter int CNT_W = DEMUX_CNT_W
) (
  input logic               clk_i,
  input logic               rst_i,
  demux_1_to_2_reg_if.slave bus
);
  logic [NUM_OUT-1:0]            w_open;
  logic [NUM_OUT-1:0]            w_fill;
  logic [NUM_OUT-1:0]            w_rdy;
  logic [NUM_OUT-1:0]            w_vld;
  logic [NUM_OUT-1:0][size-1:0]  w_data;
  logic [NUM_OUT-1:0][CNT_W-1:0] w_cnt;
  logic                          w_in_fire;

  // Ready depends only on the selected slot, never on valid_i.
  assign bus.ready_o = (bus.select_i == SEL_OUT1) ? w_open[1] : w_open[0];
  assign w_in_fire   = bus.valid_i && bus.ready_o;
  assign w_fill[0]   = w_in_fire && (bus.select_i == SEL_OUT0);
  assign w_fill[1]   = w_in_fire && (bus.select_i == SEL_OUT1);
  assign w_rdy       = {bus.ready1_i, bus.ready0_i};

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
    demux_out_slot #(.size(size), .CNT_W(CNT_W)) u_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_fill  (w_fill[g]),
      .i_data  (bus.data_i),
      .i_ready (w_rdy[g]),
      .o_open  (w_open[g]),
      .o_valid (w_vld[g]),
      .o_data  (w_data[g]),
      .o_count (w_cnt[g])
    );
  end

  assign bus.valid0_o = w_vld[0];
  assign bus.valid1_o = w_vld[1];
  assign bus.data0_o  = w_data[0];
  assign bus.data1_o  = w_data[1];
  assign bus.count0_o = w_cnt[0];
  assign bus.count1_o = w_cnt[1];
endmodule

// File: tb/tb_demux_1_to_2_reg.sv
// Directed bench for demux_1_to_2_reg: reset, streaming, backpressure, bypass, mid-reset, wrap.
module tb_demux_1_to_2_reg;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  demux_1_to_2_reg_if #(.size(32), .CNT_W(8)) bus ();
  demux_1_to_2_reg #(.size(32), .CNT_W(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] d);
    bus.valid_i  = v;
    bus.select_i = s;
    bus.data_i   = d;
    #1;
  endtask

  task automatic test_reset();
    bus.ready0_i = 1'b0;
    bus.ready1_i = 1'b0;
    drive(1'b1, 1'b0, 32'hDEAD_BEEF);
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.valid0_o !== 1'b0) begin n_err++; $display("FAIL rst_valid0 got %b exp 0", bus.valid0_o); end
    n_cmp++; if (bus.valid1_o !== 1'b0) begin n_err++; $display("FAIL rst_valid1 got %b exp 0", bus.valid1_o); end
    n_cmp++; if (bus.data0_o !== 32'h0) begin n_err++; $display("FAIL rst_data0 got %h exp 0", bus.data0_o); end
    n_cmp++; if (bus.data1_o !== 32'h0) begin n_err++; $display("FAIL rst_data1 got %h exp 0", bus.data1_o); end
    n_cmp++; if (bus.count0_o !== 8'h0 || bus.count1_o !== 8'h0) begin
      n_err++; $display("FAIL rst_counts got %h/%h exp 0/0", bus.count0_o, bus.count1_o); end
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b exp 1", bus.ready_o); end
  endtask

  task automatic test_streaming();
    logic [31:0] vec [3] = '{32'h11, 32'h22, 32'h33};
    bus.ready0_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, vec[i]);
      n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d] got %b exp 1", i, bus.ready_o); end
      tick();
      n_cmp++; if (bus.valid0_o !== 1'b1 || bus.data0_o !== vec[i]) begin
        n_err++; $display("FAIL stream_data[%0d] got %b/%h exp 1/%h", i, bus.valid0_o, bus.data0_o, vec[i]); end
      n_cmp++; if (bus.valid1_o !== 1'b0) begin n_err++; $display("FAIL stream_valid1[%0d] got %b exp 0", i, bus.valid1_o); end
    end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    n_cmp++; if (bus.count0_o !== 8'd3) begin n_err++; $display("FAIL stream_count0 got %0d exp 3", bus.count0_o); end
    n_cmp++; if (bus.valid0_o !== 1'b0) begin n_err++; $display("FAIL stream_drained got %b exp 0", bus.valid0_o); end
    n_cmp++; if (bus.count1_o !== 8'd0) begin n_err++; $display("FAIL stream_count1 got %0d exp 0", bus.count1_o); end
    bus.ready0_i = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.ready1_i = 1'b0;
    drive(1'b1, 1'b1, 32'hAA);
    n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL bp_ready_empty got %b exp 1", bus.ready_o); end
    tick();
    n_cmp++; if (bus.valid1_o !== 1'b1 || bus.data1_o !== 32'hAA) begin
      n_err++; $display("FAIL bp_hold_aa got %b/%h exp 1/aa", bus.valid1_o, bus.data1_o); end
    drive(1'b1, 1'b1, 32'hBB);
    n_cmp++; if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready_full got %b exp 0", bus.ready_o); end
    tick();
    n_cmp++; if (bus.data1_o !== 32'hAA || bus.ready_o !== 1'b0) begin
      n_err++; $display("FAIL bp_stall got %h/%b exp aa/0", bus.data1_o, bus.ready_o); end
    bus.ready1_i = 1'b1;
    #1;
    n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL bp_ready_drain got %b exp 1", bus.ready_o); end
    tick();
    n_cmp++; if (bus.valid1_o !== 1'b1 || bus.data1_o !== 32'hBB) begin
      n_err++; $display("FAIL bp_fill_bb got %b/%h exp 1/bb", bus.valid1_o, bus.data1_o); end
    n_cmp++; if (bus.count1_o !== 8'd1) begin n_err++; $display("FAIL bp_count1 got %0d exp 1", bus.count1_o); end
    bus.ready1_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_bypass();
    bus.ready0_i = 1'b0;
    drive(1'b1, 1'b0, 32'h55);
    n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL byp_ready got %b exp 1", bus.ready_o); end
    tick();
    drive(1'b0, 1'b0, 32'h0);
    n_cmp++; if (bus.valid0_o !== 1'b1 || bus.data0_o !== 32'h55) begin
      n_err++; $display("FAIL byp_out0 got %b/%h exp 1/55", bus.valid0_o, bus.data0_o); end
    n_cmp++; if (bus.valid1_o !== 1'b1 || bus.data1_o !== 32'hBB || bus.count1_o !== 8'd1) begin
      n_err++; $display("FAIL byp_slot1 got %b/%h/%0d exp 1/bb/1", bus.valid1_o, bus.data1_o, bus.count1_o); end
    drive(1'b1, 1'b1, 32'hCC);
    n_cmp++; if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL byp_sel1_blocked got %b exp 0", bus.ready_o); end
    drive(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.valid0_o !== 1'b0 || bus.valid1_o !== 1'b0) begin
      n_err++; $display("FAIL mrst_valids got %b/%b exp 0/0", bus.valid0_o, bus.valid1_o); end
    n_cmp++; if (bus.count0_o !== 8'd0 || bus.count1_o !== 8'd0) begin
      n_err++; $display("FAIL mrst_counts got %0d/%0d exp 0/0", bus.count0_o, bus.count1_o); end
    bus.ready0_i = 1'b1;
    bus.ready1_i = 1'b1;
    tick();
    n_cmp++; if (bus.valid0_o !== 1'b0 || bus.valid1_o !== 1'b0 || bus.count0_o !== 8'd0 || bus.count1_o !== 8'd0) begin
      n_err++; $display("FAIL mrst_stale got %b/%b/%0d/%0d exp 0/0/0/0",
                        bus.valid0_o, bus.valid1_o, bus.count0_o, bus.count1_o); end
  endtask

  task automatic test_wrap();
    bus.ready0_i = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, 32'(i));
      tick();
    end
    n_cmp++; if (bus.count0_o !== 8'hFF || bus.data0_o !== 32'd255) begin
      n_err++; $display("FAIL wrap_pre got %0d/%h exp 255/ff", bus.count0_o, bus.data0_o); end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    n_cmp++; if (bus.count0_o !== 8'h00) begin n_err++; $display("FAIL wrap_count0 got %0d exp 0", bus.count0_o); end
    n_cmp++; if (bus.count1_o !== 8'h00) begin n_err++; $display("FAIL wrap_count1 got %0d exp 0", bus.count1_o); end
  endtask

  initial begin
    bus.valid_i  = 1'b0;
    bus.select_i = 1'b0;
    bus.data_i   = '0;
    bus.ready0_i = 1'b0;
    bus.ready1_i = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bypass();
    test_mid_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
